button_conditioner: RTL and testbench

Input conditioning stage for the helicopter game's pushbuttons, sitting directly upstream of the pipelined processor's button inputs. It synchronizes each raw active-low board pushbutton to `clock` and debounces it. It presents the processor with a clean active-high level plus single-cycle press, release and auto-repeat pulses. This replaces the bare inversion of the raw pins at the top level.

---
 rtl/btn_pkg.sv | 20 ++
 rtl/btn_debounce_ch.sv | 122 ++++++++++++
 rtl/button_conditioner.sv | 35 +++
 tb/tb_button_conditioner.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default sizing for the pushbutton conditioning slice.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } btn_state_e;

   localparam int unsigned DEF_NUM_BTN         = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
   localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
   localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One pushbutton channel: 2-flop synchronizer, debounce FSM, auto-repeat timer.
//   state           | meaning
//   ST_IDLE         | released and stable
//   ST_PRESS_WAIT   | pressed samples being counted toward acceptance
//   ST_HELD         | press accepted, repeat timer running
//   ST_RELEASE_WAIT | released samples being counted, repeat timer frozen
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic clock,
   input  logic aclr,
   input  logic i_pb_n,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_repeat
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [CW-1:0] C_DEB = CW'(DEBOUNCE_CYCLES);
   localparam logic [RW-1:0] C_DLY = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] C_PER = RW'(REPEAT_PERIOD);
   localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

   logic          r_sync1;
   logic          r_sync2;
   btn_state_e    r_state;
   logic [CW-1:0] r_cnt;
   logic [RW-1:0] r_rcnt;
   logic          r_first;
   logic          r_level;
   logic          r_press;
   logic          r_release;
   logic          r_repeat;
   logic          w_s;
   logic [RW-1:0] w_rtarget;

   assign w_s       = r_sync2;
   assign w_rtarget = r_first ? C_DLY : C_PER;

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_rcnt    <= '0;
         r_first   <= 1'b0;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
      end else begin
         r_sync1   <= ~i_pb_n;
         r_sync2   <= r_sync1;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_s) begin
                  r_state <= ST_PRESS_WAIT;
                  r_cnt   <= CW'(1);
               end
            end
            ST_PRESS_WAIT: begin
               if (!w_s) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == C_DEB) begin
                  r_state <= ST_HELD;
                  r_level <= 1'b1;
                  r_press <= 1'b1;
                  r_rcnt  <= '0;
                  r_first <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_HELD: begin
               if (!w_s) begin
                  r_state <= ST_RELEASE_WAIT;
                  r_cnt   <= CW'(1);
               end else if (REPEAT_EN) begin
                  // Compare before incrementing so the first tick lands REPEAT_DELAY+1 edges after the press.
                  if (r_rcnt == w_rtarget) begin
                     r_repeat <= 1'b1;
                     r_rcnt   <= '0;
                     r_first  <= 1'b0;
                  end else begin
                     r_rcnt <= r_rcnt + 1'b1;
                  end
               end
            end
            ST_RELEASE_WAIT: begin
               if (w_s) begin
                  r_state <= ST_HELD;
               end else if (r_cnt == C_DEB) begin
                  r_state   <= ST_IDLE;
                  r_level   <= 1'b0;
                  r_release <= 1'b1;
                  r_cnt     <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN raw active-low pushbuttons into clean levels and one-cycle pulses.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned NUM_BTN         = DEF_NUM_BTN,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic               clock,
   input  logic               aclr,
   input  logic [NUM_BTN-1:0] pb_n,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_repeat
);

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clock    (clock),
         .aclr     (aclr),
         .i_pb_n   (pb_n[g]),
         .o_level  (btn_level[g]),
         .o_press  (btn_press[g]),
         .o_release(btn_release[g]),
         .o_repeat (btn_repeat[g])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, corner sequences, random run vs run-length model.
module tb_button_conditioner;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic       clock = 1'b0;
   logic       aclr;
   logic [1:0] pb_n;
   logic [1:0] btn_level, btn_press, btn_release, btn_repeat;

   always #5 clock = ~clock;

   button_conditioner #(
      .NUM_BTN(2), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .clock(clock), .aclr(aclr), .pb_n(pb_n),
      .btn_level(btn_level), .btn_press(btn_press),
      .btn_release(btn_release), .btn_repeat(btn_repeat)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: synchronizer as a 2-deep delay line, acceptance after D+1
   // consecutive disagreeing samples, repeats from a count of active held ticks.
   int         m_q1[2], m_q2[2], m_run[2], m_n[2];
   logic [1:0] m_lvl, m_prs, m_rel, m_rpt;

   typedef struct {
      logic [1:0] pb;
      logic [1:0] lvl, prs, rel, rpt;
   } vec_t;
   vec_t tbl[30];

   task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         m_q1[c] = 0; m_q2[c] = 0; m_run[c] = 0; m_n[c] = 0;
      end
      m_lvl = '0; m_prs = '0; m_rel = '0; m_rpt = '0;
   endtask

   task automatic model_edge(input logic [1:0] pbn);
      for (int c = 0; c < 2; c++) begin
         int s;
         s = m_q2[c];
         m_prs[c] = 1'b0; m_rel[c] = 1'b0; m_rpt[c] = 1'b0;
         if (s != int'(m_lvl[c])) begin
            m_run[c]++;
            if (m_run[c] == D + 1) begin
               m_lvl[c] = (s == 1);
               m_run[c] = 0;
               if (s == 1) begin
                  m_prs[c] = 1'b1;
                  m_n[c]   = 0;
               end else begin
                  m_rel[c] = 1'b1;
               end
            end
         end else begin
            if (m_lvl[c] && m_run[c] == 0 && RD != 0) begin
               m_n[c]++;
               if (m_n[c] == RD + 1 || (m_n[c] > RD + 1 && (m_n[c] - RD - 1) % (RP + 1) == 0))
                  m_rpt[c] = 1'b1;
            end
            m_run[c] = 0;
         end
         m_q2[c] = m_q1[c];
         m_q1[c] = pbn[c] ? 0 : 1;
      end
   endtask

   task automatic cycle(input logic [1:0] pbn);
      pb_n = pbn;
      @(posedge clock);
      model_edge(pbn);
      #1;
      chk("mdl_level",   btn_level,   m_lvl);
      chk("mdl_press",   btn_press,   m_prs);
      chk("mdl_release", btn_release, m_rel);
      chk("mdl_repeat",  btn_repeat,  m_rpt);
      @(negedge clock);
   endtask

   // Asserted while the clock is low; outputs must clear without any edge.
   task automatic do_reset(input logic [1:0] pbn);
      pb_n = pbn;
      aclr = 1'b1;
      model_reset();
      #1;
      chk("rst_level",   btn_level,   2'b00);
      chk("rst_press",   btn_press,   2'b00);
      chk("rst_release", btn_release, 2'b00);
      chk("rst_repeat",  btn_repeat,  2'b00);
      @(posedge clock); @(negedge clock);
      @(posedge clock); @(negedge clock);
      aclr = 1'b0;
   endtask

   initial begin
      int cnt_a, cnt_b;
      int hold[2];
      logic [1:0] rpb;

      // Clean press of ch0 from reset, one repeat, then release.
      for (int i = 0; i < 30; i++) begin
         tbl[i].pb  = (i < 20) ? 2'b10 : 2'b11;
         tbl[i].lvl = {1'b0, (i >= D + 2) && (i < 20 + D + 2)};
         tbl[i].prs = {1'b0, i == D + 2};
         tbl[i].rel = {1'b0, i == 20 + D + 2};
         tbl[i].rpt = {1'b0, i == D + 2 + RD + 1};
      end

      aclr = 1'b0;
      pb_n = 2'b11;
      #2;
      do_reset(2'b11);
      for (int i = 0; i < 30; i++) begin
         cycle(tbl[i].pb);
         chk("tbl_level",   btn_level,   tbl[i].lvl);
         chk("tbl_press",   btn_press,   tbl[i].prs);
         chk("tbl_release", btn_release, tbl[i].rel);
         chk("tbl_repeat",  btn_repeat,  tbl[i].rpt);
      end

      // Bounce: 2-cycle toggles for 20 cycles, stable low from cycle 20.
      do_reset(2'b11);
      cnt_a = 0;
      for (int k = 0; k < 30; k++) begin
         logic b;
         b = (k < 20) ? (((k / 2) % 2) == 1) : 1'b0;
         cycle({1'b1, b});
         if (k == 20 + D + 2) chk("bounce_press", btn_press, 2'b01);
         else cnt_a += btn_press[0] + btn_release[0];
      end
      chk_int("bounce_spurious", cnt_a, 0);

      // Auto-repeat timing relative to the press edge.
      do_reset(2'b11);
      for (int k = 0; k <= D + 2; k++) cycle(2'b10);
      chk("rep_press", btn_press, 2'b01);
      chk("rep_at_press", btn_repeat, 2'b00);
      for (int j = 1; j <= 40; j++) begin
         logic e;
         cycle(2'b10);
         e = (j == 11 || j == 17 || j == 23 || j == 29 || j == 35);
         chk("rep_tick", btn_repeat, {1'b0, e});
      end

      // Release glitch of 3 samples while held, then a real release.
      cnt_a = 0; cnt_b = 0;
      for (int k = 0; k < 3; k++) begin
         cycle(2'b11);
      end
      for (int k = 0; k < 25; k++) begin
         cycle(2'b10);
         cnt_a += btn_release[0];
         cnt_b += (btn_level[0] == 1'b0);
      end
      chk_int("glitch_release", cnt_a, 0);
      chk_int("glitch_level_drop", cnt_b, 0);
      cnt_a = 0;
      for (int k = 0; k < 10; k++) begin
         cycle(2'b11);
         cnt_a += btn_release[0];
      end
      chk_int("final_release_count", cnt_a, 1);
      chk("final_level", btn_level, 2'b00);

      // Both buttons on the same edge; then reset while held.
      do_reset(2'b11);
      for (int k = 0; k <= D + 2; k++) cycle(2'b00);
      chk("simul_press", btn_press, 2'b11);
      chk("simul_level", btn_level, 2'b11);
      do_reset(2'b00);

      // Reset during press debounce (cnt=3) with button still held.
      do_reset(2'b11);
      for (int k = 0; k < 5; k++) cycle(2'b10);
      do_reset(2'b10);
      cnt_a = 0;
      for (int k = 0; k <= D + 2; k++) begin
         cycle(2'b10);
         if (k < D + 2) cnt_a += btn_press[0] + btn_level[0];
      end
      chk_int("rstmid_early", cnt_a, 0);
      chk("rstmid_press", btn_press, 2'b01);

      // Random hold lengths per channel with occasional resets.
      do_reset(2'b11);
      rpb = 2'b11;
      hold[0] = 0; hold[1] = 0;
      for (int k = 0; k < 4000; k++) begin
         for (int c = 0; c < 2; c++) begin
            if (hold[c] == 0) begin
               rpb[c]  = $urandom_range(0, 1);
               hold[c] = $urandom_range(1, 12);
            end
            hold[c]--;
         end
         if ($urandom_range(0, 599) == 0) do_reset(rpb);
         cycle(rpb);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
